// File: rtl/core_acc_sched.sv
// core_acc_sched: shares one accumulation unit (counter + MAC) among NUM_REQ
// partial-sum producers. One requester owns the accumulator for a whole
// cfg_acc_num-deep group; ownership rotates round-robin. Each returned result
// is tagged with its owner through a small in-flight tag FIFO.
//
// Build option:
//   CORE_ACC_SCHED_PRIO_EN  defined   -> fixed-priority arbitration (lowest
//                                        valid index wins), no rotation pointer
//                           undefined -> round-robin arbitration (default)
//
// rst is synchronous, active-high, and must coincide with the accumulator's
// reset so that no partial group survives on either side.

`ifndef ODATA_WIDTH
`define ODATA_WIDTH 32
`endif
`ifndef CDATA_ACCU_NUM_WIDTH
`define CDATA_ACCU_NUM_WIDTH 8
`endif

module core_acc_sched #(
  parameter int NUM_REQ              = 4,
  parameter int REQ_ID_WIDTH         = $clog2(NUM_REQ),
  parameter int IDATA_WIDTH          = `ODATA_WIDTH,
  parameter int ODATA_BIT            = `ODATA_WIDTH,
  parameter int CDATA_ACCU_NUM_WIDTH = `CDATA_ACCU_NUM_WIDTH,
  parameter int TAG_DEPTH            = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CDATA_ACCU_NUM_WIDTH-1:0] cfg_acc_num,
  input  logic [NUM_REQ*IDATA_WIDTH-1:0]  req_psum,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [CDATA_ACCU_NUM_WIDTH-1:0] acc_cfg_acc_num,
  output logic [IDATA_WIDTH-1:0]          acc_idata,
  output logic                            acc_idata_valid,
  input  logic [ODATA_BIT-1:0]            acc_odata,
  input  logic                            acc_odata_valid,
  output logic [ODATA_BIT-1:0]            res_data,
  output logic [REQ_ID_WIDTH-1:0]         res_id,
  output logic                            res_valid,
  output logic                            busy,
  output logic                            cfg_err,
  output logic                            err_underflow
);

  // Pointers rely on natural binary wrap, so TAG_DEPTH must be a power of 2
  // and at least 2.
  localparam int TAG_PTR_W = $clog2(TAG_DEPTH);
  localparam int TAG_CNT_W = $clog2(TAG_DEPTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                          state;
  state_t                          state_nxt;
  logic [REQ_ID_WIDTH-1:0]         grant;
  logic [CDATA_ACCU_NUM_WIDTH-1:0] burst_cnt;

  // Arbiter result for the current IDLE cycle
  logic                            arb_found;
  logic [REQ_ID_WIDTH-1:0]         arb_idx;

  // Granted requester's lane
  logic                            sel_valid;
  logic [IDATA_WIDTH-1:0]          sel_psum;

  logic                            grant_go;
  logic                            hs;
  logic                            burst_done;

  // In-flight tag FIFO
  logic [REQ_ID_WIDTH-1:0]         tag_mem [TAG_DEPTH];
  logic [TAG_PTR_W-1:0]            tag_wr_ptr;
  logic [TAG_PTR_W-1:0]            tag_rd_ptr;
  logic [TAG_CNT_W-1:0]            tag_count;
  logic                            tag_full;
  logic                            tag_empty;
  logic                            tag_push;
  logic                            tag_pop;

`ifndef CORE_ACC_SCHED_PRIO_EN
  logic [REQ_ID_WIDTH-1:0]         rr_ptr;
`endif

  // ---------------------------------------------------------------------------
  // Status and control strobes
  // ---------------------------------------------------------------------------
  assign cfg_err    = (cfg_acc_num == '0);
  assign tag_full   = (tag_count == TAG_CNT_W'(TAG_DEPTH));
  assign tag_empty  = (tag_count == '0);
  assign busy       = (state == BURST) || !tag_empty;

  // A grant needs a usable group length and a free tag slot for its result.
  assign grant_go   = (state == IDLE) && !cfg_err && !tag_full && arb_found;
  assign hs         = (state == BURST) && sel_valid;
  assign burst_done = hs && (burst_cnt == acc_cfg_acc_num - 1'b1);

  assign tag_push   = burst_done;
  assign tag_pop    = acc_odata_valid && !tag_empty;

  // ---------------------------------------------------------------------------
  // Arbitration: pick the next requester while IDLE
  // ---------------------------------------------------------------------------
`ifdef CORE_ACC_SCHED_PRIO_EN
  // Fixed priority: lowest valid index wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!arb_found && req_valid[k]) begin
        arb_found = 1'b1;
        arb_idx   = REQ_ID_WIDTH'(k);
      end
    end
  end
`else
  // Round-robin: first valid index at or above rr_ptr, wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    int cand;
    cand      = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = REQ_ID_WIDTH'(cand);
      end
    end
  end
`endif

  // Route the granted requester's valid and psum onto the shared lane
  always_comb begin
    sel_valid = 1'b0;
    sel_psum  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(grant) == k) begin
        sel_valid = req_valid[k];
        sel_psum  = req_psum[k*IDATA_WIDTH +: IDATA_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: leave IDLE on a grant, return after the group's last psum
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_go)   state_nxt = BURST;
      BURST:   if (burst_done) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Outputs: only the owning requester sees ready, and only during a burst
  always_comb begin
    req_ready = '0;
    if (state == BURST) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (int'(grant) == k) req_ready[k] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Grant, latched group length and burst counter
  // ---------------------------------------------------------------------------
  // Capture owner and group length at grant; count accepted psums in the burst
  always_ff @(posedge clk) begin
    if (rst) begin
      grant           <= '0;
      acc_cfg_acc_num <= '0;
      burst_cnt       <= '0;
    end else begin
      if (grant_go) begin
        grant           <= arb_idx;
        acc_cfg_acc_num <= cfg_acc_num;
      end
      if (hs) begin
        if (burst_done) burst_cnt <= '0;
        else            burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

`ifndef CORE_ACC_SCHED_PRIO_EN
  // Rotate priority to the requester after the one whose group just closed
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (burst_done) begin
      rr_ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Psum datapath to the accumulator (one cycle latency)
  // ---------------------------------------------------------------------------
  // Register the accepted psum; valid pulses once per handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_idata       <= '0;
      acc_idata_valid <= 1'b0;
    end else begin
      acc_idata_valid <= hs;
      if (hs) acc_idata <= sel_psum;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag FIFO
  // ---------------------------------------------------------------------------
  // Pointer and occupancy bookkeeping; simultaneous push and pop keeps count
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_count  <= '0;
    end else begin
      if (tag_push) tag_wr_ptr <= tag_wr_ptr + 1'b1;
      if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + 1'b1;
      case ({tag_push, tag_pop})
        2'b10:   tag_count <= tag_count + 1'b1;
        2'b01:   tag_count <= tag_count - 1'b1;
        default: tag_count <= tag_count;
      endcase
    end
  end

  // Tag storage: write the owner of each closed group
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers and
    // count gate every read, so stale entries are never observed.
    if (tag_push) tag_mem[tag_wr_ptr] <= grant;
  end

  // ---------------------------------------------------------------------------
  // Result path
  // ---------------------------------------------------------------------------
  // Tag each accumulator result with its owner; flag results with no owner
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid     <= 1'b0;
      res_data      <= '0;
      res_id        <= '0;
      err_underflow <= 1'b0;
    end else begin
      res_valid <= tag_pop;
      if (tag_pop) begin
        res_data <= acc_odata;
        res_id   <= tag_mem[tag_rd_ptr];
      end
      if (acc_odata_valid && tag_empty) err_underflow <= 1'b1;
    end
  end

endmodule

// File: doc/core_acc_sched.md
Name: core_acc_sched

Overview:
- Shares one accumulation unit (counter plus MAC, `cfg_acc_num`-deep groups) among NUM_REQ partial-sum producers.
- Grants one requester per whole accumulation group, in round-robin order.
- Forwards that requester's psums to the accumulator and drives its group-length config.
- Tags each returned result with the owning requester ID through an in-flight tag FIFO.
- Sits between the per-head psum sources and the shared accumulator.

Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- REQ_ID_WIDTH, $clog2(NUM_REQ), requester ID width
- IDATA_WIDTH, `ODATA_WIDTH, psum width
- ODATA_BIT, `ODATA_WIDTH, result width
- CDATA_ACCU_NUM_WIDTH, `CDATA_ACCU_NUM_WIDTH, group-length width
- TAG_DEPTH, 4, in-flight tag FIFO depth (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cfg_acc_num  in  CDATA_ACCU_NUM_WIDTH  psums per group
- req_psum  in  NUM_REQ*IDATA_WIDTH  packed psums; requester i at [i*IDATA_WIDTH +: IDATA_WIDTH]
- req_valid  in  NUM_REQ  psum valid per requester
- req_ready  out  NUM_REQ  psum accept per requester
- acc_cfg_acc_num  out  CDATA_ACCU_NUM_WIDTH  group length driven to accumulator
- acc_idata  out  IDATA_WIDTH  psum to accumulator
- acc_idata_valid  out  1  psum valid to accumulator
- acc_odata  in  ODATA_BIT  accumulator result
- acc_odata_valid  in  1  accumulator result valid
- res_data  out  ODATA_BIT  tagged result
- res_id  out  REQ_ID_WIDTH  owner of res_data
- res_valid  out  1  result valid, single-cycle pulse, no backpressure
- busy  out  1  burst active or tags in flight
- cfg_err  out  1  cfg_acc_num == 0
- err_underflow  out  1  sticky: result returned with tag FIFO empty

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high. All state updates on posedge clk.
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; tag FIFO empty; burst counter 0; latched cfg 0.
- Integration: rst must coincide with accumulator reset.

State machine:
- IDLE:
  - If cfg_acc_num != 0, tag FIFO not full and any req_valid: register grant = first valid index searching from rr_ptr upward (wrapping); latch cfg_acc_num into acc_cfg_acc_num; go to BURST.
  - Otherwise stay in IDLE.
- BURST:
  - req_ready[grant] = 1; all other req_ready = 0. req_ready is 0 in IDLE.
  - Handshake = req_valid[grant] && req_ready[grant].
  - On each handshake, increment burst counter.
  - On the handshake with counter == latched cfg − 1: push grant into tag FIFO, clear counter, rr_ptr = grant+1 (mod NUM_REQ), go to IDLE.
  - Granted requester stalling (valid low) holds BURST indefinitely; no timeout.

Timing:
- One bubble cycle between consecutive bursts (the IDLE arbitration cycle).
- Datapath: acc_idata/acc_idata_valid registered from the handshake, 1-cycle latency; acc_idata_valid = 1 exactly once per handshake.
- Result path: on acc_odata_valid, pop the tag FIFO. Next cycle: res_valid=1, res_data=acc_odata, res_id=popped tag.
- End-to-end: last psum handshake in cycle c → res_valid in cycle c+4.

Config and tag FIFO:
- cfg_acc_num changes mid-burst are ignored until the next IDLE.
- cfg_err = (cfg_acc_num == 0) combinationally; no grants issue while it is set.
- Tag FIFO: full blocks new grants. Simultaneous push and pop is allowed, occupancy unchanged. Pointers wrap modulo TAG_DEPTH.
- acc_odata_valid with tag FIFO empty: set err_underflow, which stays set until rst; res_valid stays 0 and the pointers are unchanged.

busy:
- busy = (state==BURST) || FIFO not empty.

Reset mid-burst:
- Burst aborts, partial count and tags are discarded, and no res_valid is produced for the aborted group.

Optional Feature:
- CORE_ACC_SCHED_PRIO_EN defined: arbitration is fixed priority (lowest valid index wins); rr_ptr is not implemented.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- cfg=4, req0 sends 1,2,3,4 back-to-back (last handshake cycle c) → acc_idata_valid high 4 cycles; res_valid at c+4 with res_data=10, res_id=0; busy drops the cycle after.
- cfg=2, req0 and req1 both continuously valid → grants 0,1,0,1; results ids 0,1,0,1; one IDLE cycle between bursts; req_ready never high for both requesters in the same cycle.
- cfg=0 with all req_valid high → cfg_err=1, req_ready stays 0 for 20 cycles; then cfg=3 → first grant to req0 on the next cycle.
- cfg=1, all four requesters valid, TAG_DEPTH=2 → tag FIFO fills and grants stall until pops; res ids 0,1,2,3 in order; no result lost.
- req2 mid-burst (2 of 4 psums accepted), rst pulsed 1 cycle → all outputs 0 the next cycle; no res_valid afterwards; a new burst starts from grant 0.
- acc_odata_valid injected while FIFO empty → err_underflow=1 and stays 1; res_valid stays 0. With CORE_ACC_SCHED_PRIO_EN and req1 and req3 always valid → req1 always granted.
